// File: rtl/regfile_write_buffer.sv
`default_nettype none
// ============================================================================
// Module : regfile_write_buffer
// Desc   : Writeback FIFO draining into the register file write port, with
//          two combinational bypass lookups over pending entries.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        inValid,
    output logic                        inReady,
    input  logic [ADDR_W-1:0]           inRegister,
    input  logic [DATA_W-1:0]           inData,
    input  logic                        drainEnable,
    output logic                        regWrite,
    output logic [ADDR_W-1:0]           writeRegister,
    output logic [DATA_W-1:0]           writeData,
    input  logic [ADDR_W-1:0]           lookupRegister1,
    input  logic [ADDR_W-1:0]           lookupRegister2,
    output logic                        lookupHit1,
    output logic                        lookupHit2,
    output logic [DATA_W-1:0]           lookupData1,
    output logic [DATA_W-1:0]           lookupData2,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ADDR_W-1:0]  r_reg_mem  [DEPTH];
    logic [DATA_W-1:0]  r_data_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    logic [c_PTR_W-1:0] w_age_idx [DEPTH];
    logic [DEPTH-1:0]   w_age_vld;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // Full blocks acceptance even when a pop happens in the same cycle.
    assign inReady  = !w_full && !reset;
    assign w_push   = inValid && inReady;
    assign regWrite = !w_empty && drainEnable;
    assign w_pop    = regWrite;

    assign writeRegister = r_reg_mem[r_rptr];
    assign writeData     = r_data_mem[r_rptr];
    assign count         = r_count;
    assign empty         = w_empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_reg_mem[r_wptr]  <= inRegister;
            r_data_mem[r_wptr] <= inData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Slot holding the k-th oldest pending entry; validity comes from count,
    // so stale contents after reset can never hit.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign w_age_idx[k] = r_rptr + c_PTR_W'(k);
        assign w_age_vld[k] = (c_CNT_W'(k) < r_count);
    end

    for (genvar p = 0; p < 2; p++) begin : g_lookup
        logic [ADDR_W-1:0] w_query;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;

        assign w_query = (p == 0) ? lookupRegister1 : lookupRegister2;

        // Scanning oldest to youngest lets the youngest match win.
        always_comb begin
            w_hit  = 1'b0;
            w_data = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_age_vld[k] && (r_reg_mem[w_age_idx[k]] == w_query)) begin
                    w_hit  = 1'b1;
                    w_data = r_data_mem[w_age_idx[k]];
                end
            end
        end
    end

    assign lookupHit1  = g_lookup[0].w_hit;
    assign lookupData1 = g_lookup[0].w_data;
    assign lookupHit2  = g_lookup[1].w_hit;
    assign lookupData2 = g_lookup[1].w_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_write_buffer
// Desc   : Directed self-checking bench for regfile_write_buffer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inRegister;
    logic [31:0] inData;
    logic        drainEnable;
    logic        regWrite;
    logic [3:0]  writeRegister;
    logic [31:0] writeData;
    logic [3:0]  lookupRegister1;
    logic [3:0]  lookupRegister2;
    logic        lookupHit1;
    logic        lookupHit2;
    logic [31:0] lookupData1;
    logic [31:0] lookupData2;
    logic [2:0]  count;
    logic        empty;

    int vectors     = 0;
    int miscompares = 0;

    regfile_write_buffer #(.DEPTH(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .inValid         (inValid),
        .inReady         (inReady),
        .inRegister      (inRegister),
        .inData          (inData),
        .drainEnable     (drainEnable),
        .regWrite        (regWrite),
        .writeRegister   (writeRegister),
        .writeData       (writeData),
        .lookupRegister1 (lookupRegister1),
        .lookupRegister2 (lookupRegister2),
        .lookupHit1      (lookupHit1),
        .lookupHit2      (lookupHit2),
        .lookupData1     (lookupData1),
        .lookupData2     (lookupData2),
        .count           (count),
        .empty           (empty)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        inValid         = 1'b0;
        inRegister      = '0;
        inData          = '0;
        drainEnable     = 1'b0;
        lookupRegister1 = '0;
        lookupRegister2 = '0;

        // Reset state
        tick();
        #1;
        check("rst_count",   count, 0);
        check("rst_empty",   empty, 1);
        check("rst_regwr",   regWrite, 0);
        check("rst_inready", inReady, 0);
        check("rst_hit1",    lookupHit1, 0);
        check("rst_data1",   lookupData1, 0);
        check("rst_hit2",    lookupHit2, 0);
        reset = 1'b0;
        #1;
        check("post_rst_inready", inReady, 1);

        // Single push, one-cycle latency, lookup valid while popping
        drainEnable = 1'b1;
        inValid     = 1'b1;
        inRegister  = 4'd5;
        inData      = 32'hDEADBEEF;
        #1;
        check("no_passthru_regwr", regWrite, 0);
        tick();
        inValid         = 1'b0;
        lookupRegister1 = 4'd5;
        #1;
        check("single_regwr", regWrite, 1);
        check("single_reg",   writeRegister, 5);
        check("single_data",  writeData, 32'hDEADBEEF);
        check("single_count", count, 1);
        check("single_hit",   lookupHit1, 1);
        check("single_ldata", lookupData1, 32'hDEADBEEF);
        tick();
        #1;
        check("single_empty", empty, 1);
        check("single_regwr0", regWrite, 0);
        check("single_hit0",  lookupHit1, 0);

        // Fill with draining stalled
        drainEnable = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            inValid    = 1'b1;
            inRegister = 4'(i);
            inData     = 32'(i * 32'h11);
            tick();
        end
        inRegister = 4'd6;
        inData     = 32'h66;
        #1;
        check("full_count",   count, 4);
        check("full_inready", inReady, 0);
        check("full_regwr",   regWrite, 0);
        tick();
        #1;
        check("held_count", count, 4);
        drainEnable = 1'b1;
        #1;
        check("drain1_regwr",   regWrite, 1);
        check("drain1_reg",     writeRegister, 1);
        check("drain1_data",    writeData, 32'h11);
        check("drain1_inready", inReady, 0);
        tick();
        #1;
        check("drain2_count",   count, 3);
        check("drain2_inready", inReady, 1);
        check("drain2_reg",     writeRegister, 2);
        check("drain2_data",    writeData, 32'h22);
        tick();
        inValid = 1'b0;
        #1;
        check("drain3_count", count, 3);
        check("drain3_reg",   writeRegister, 3);
        check("drain3_data",  writeData, 32'h33);
        tick();
        #1;
        check("drain4_reg",  writeRegister, 4);
        check("drain4_data", writeData, 32'h44);
        tick();
        #1;
        check("drain5_count", count, 1);
        check("drain5_reg",   writeRegister, 6);
        check("drain5_data",  writeData, 32'h66);
        tick();
        #1;
        check("drain_empty", empty, 1);

        // Back-to-back pushes across pointer wrap
        for (int i = 0; i < 10; i++) begin
            inValid    = 1'b1;
            inRegister = 4'(i);
            inData     = 32'h1000 + 32'(i);
            tick();
            check("wrap_regwr", regWrite, 1);
            check("wrap_reg",   writeRegister, 64'(i));
            check("wrap_data",  writeData, 64'h1000 + 64'(i));
            check("wrap_count", count, 1);
        end
        inValid = 1'b0;
        tick();
        #1;
        check("wrap_empty", empty, 1);

        // Bypass: youngest matching entry wins
        drainEnable = 1'b0;
        inValid = 1'b1; inRegister = 4'd7; inData = 32'hA; tick();
        inRegister = 4'd3; inData = 32'hB; tick();
        inRegister = 4'd7; inData = 32'hC; tick();
        inValid = 1'b0;
        lookupRegister1 = 4'd7;
        lookupRegister2 = 4'd3;
        #1;
        check("byp_hit7",  lookupHit1, 1);
        check("byp_data7", lookupData1, 32'hC);
        check("byp_hit3",  lookupHit2, 1);
        check("byp_data3", lookupData2, 32'hB);
        lookupRegister2 = 4'd9;
        #1;
        check("byp_hit9",  lookupHit2, 0);
        check("byp_data9", lookupData2, 0);

        // Drain to count 2, then simultaneous push and pop
        drainEnable = 1'b1;
        tick();
        check("pp_pre_count", count, 2);
        check("pp_pre_data7", lookupData1, 32'hC);
        inValid = 1'b1; inRegister = 4'd0; inData = 32'hF0;
        tick();
        inValid = 1'b0;
        lookupRegister2 = 4'd3;
        #1;
        check("pp_count", count, 2);
        check("pp_reg",   writeRegister, 7);
        check("pp_data",  writeData, 32'hC);
        check("pp_miss3", lookupHit2, 0);
        lookupRegister2 = 4'd0;
        #1;
        check("pp_hit0",  lookupHit2, 1);
        check("pp_data0", lookupData2, 32'hF0);
        tick();
        #1;
        check("pp_reg0",  writeRegister, 0);
        check("pp_wdata0", writeData, 32'hF0);
        tick();
        #1;
        check("pp_empty", empty, 1);
        check("pp_miss7", lookupHit1, 0);
        check("pp_miss0", lookupHit2, 0);
        check("pp_mdata", lookupData1, 0);

        // Reset mid-operation with three entries pending
        drainEnable = 1'b0;
        inValid = 1'b1; inRegister = 4'd2; inData = 32'h200; tick();
        inRegister = 4'd4; inData = 32'h400; tick();
        inRegister = 4'd6; inData = 32'h600; tick();
        lookupRegister1 = 4'd2;
        #1;
        check("mid_count", count, 3);
        check("mid_hit",   lookupHit1, 1);
        reset       = 1'b1;
        drainEnable = 1'b1;
        #1;
        check("mid_rst_inready", inReady, 0);
        tick();
        reset   = 1'b0;
        inValid = 1'b0;
        #1;
        check("mid_rst_count",   count, 0);
        check("mid_rst_regwr",   regWrite, 0);
        check("mid_rst_hit",     lookupHit1, 0);
        check("mid_rst_data",    lookupData1, 0);
        check("mid_rst_inready", inReady, 1);
        check("mid_rst_empty",   empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
